// File: rtl/ofm_pkg.sv
// Shared definitions for the OFM write-back path: FSM encoding, pack-factor
// derivation and the ReLU clamp decision reused by requantise blocks.
package ofm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ofm_state_t;

    // Number of WI-bit elements that fit in one BRAM word.
    function automatic int pack_factor(input int data_w, input int elem_w);
        return data_w / elem_w;
    endfunction

    // True when a signed element must be forced to zero by ReLU.
    function automatic logic relu_clamp(input logic relu_en, input logic sign_bit);
        return relu_en && sign_bit;
    endfunction

endpackage

// File: rtl/ofm_lane_packer.sv
// Accumulates elements into lanes of one BRAM word and presents the word with
// its strobes for a single cycle when told to emit, then starts a fresh word.
module ofm_lane_packer
    import ofm_pkg::*;
#(
    parameter int WI     = 8,
    parameter int PACK   = 4,
    parameter int LANE_W = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_clr,
    input  logic                 i_wr,
    input  logic                 i_emit,
    input  logic [LANE_W-1:0]    i_lane,
    input  logic [WI-1:0]        i_data,
    output logic [WI*PACK-1:0]   o_data,
    output logic [PACK-1:0]      o_we
);

    logic [WI*PACK-1:0] r_pack;
    logic [PACK-1:0]    r_strb;
    logic [WI*PACK-1:0] w_pack_nxt;
    logic [PACK-1:0]    w_strb_nxt;

    // NOTE: both outputs get a default before the loop so no latch is inferred.
    always_comb begin
        w_pack_nxt = r_pack;
        w_strb_nxt = r_strb;
        for (int i = 0; i < PACK; i++) begin
            if (i_lane == LANE_W'(i)) begin
                w_pack_nxt[i*WI +: WI] = i_data;
                w_strb_nxt[i]          = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pack <= '0;
            r_strb <= '0;
            o_data <= '0;
            o_we   <= '0;
        end else begin
            o_we <= '0;
            if (i_clr) begin
                r_pack <= '0;
                r_strb <= '0;
            end else if (i_wr) begin
                if (i_emit) begin
                    // Unfilled lanes are already zero because the word was cleared.
                    o_data <= w_pack_nxt;
                    o_we   <= w_strb_nxt;
                    r_pack <= '0;
                    r_strb <= '0;
                end else begin
                    r_pack <= w_pack_nxt;
                    r_strb <= w_strb_nxt;
                end
            end
        end
    end

endmodule

// File: rtl/ofm_pack_writer.sv
// Packs the serial conv output stream into BRAM words and writes them from a
// programmable base address; ap_start/ap_done handshake, sticky overflow flag.
module ofm_pack_writer
    import ofm_pkg::*;
#(
    parameter int WI                 = 8,
    parameter int BRAM_DATA_WIDTH    = 32,
    parameter int BRAM_ADDRESS_WIDTH = 14,
    parameter int DIM_W              = 9,
    parameter int CNT_W              = 24
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   ap_start,
    input  logic [BRAM_ADDRESS_WIDTH-1:0]          base_addr,
    input  logic [DIM_W-1:0]                       ofm_w,
    input  logic [DIM_W-1:0]                       ofm_h,
    input  logic [DIM_W-1:0]                       out_ch,
    input  logic                                   relu_en,
    input  logic [WI-1:0]                          din,
    input  logic                                   din_vld,
    output logic                                   din_rdy,
    output logic [BRAM_ADDRESS_WIDTH-1:0]          bram_addr,
    output logic [BRAM_DATA_WIDTH-1:0]             bram_data,
    output logic [BRAM_DATA_WIDTH/WI-1:0]          bram_we,
    output logic                                   ap_done,
    output logic                                   ap_idle,
    output logic                                   err_overflow
);

    localparam int PACK   = pack_factor(BRAM_DATA_WIDTH, WI);
    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);

    ofm_state_t                     r_state;
    logic [BRAM_ADDRESS_WIDTH-1:0]  r_base;
    logic [BRAM_ADDRESS_WIDTH-1:0]  r_word_idx;
    logic [BRAM_ADDRESS_WIDTH-1:0]  r_addr;
    logic                           r_relu;
    logic [CNT_W-1:0]               r_total;
    logic [CNT_W-1:0]               r_elem_cnt;
    logic [LANE_W-1:0]              r_lane;
    logic                           r_din_rdy;
    logic                           r_done;
    logic                           r_idle;
    logic                           r_err;

    logic [CNT_W-1:0]               w_total;
    logic                           w_start;
    logic                           w_xfer;
    logic                           w_last;
    logic                           w_emit;
    logic [WI-1:0]                  w_elem;

    assign w_total = CNT_W'(ofm_w) * CNT_W'(ofm_h) * CNT_W'(out_ch);
    assign w_start = (r_state == ST_IDLE) && ap_start;
    assign w_xfer  = din_vld && r_din_rdy;
    assign w_last  = (r_elem_cnt == r_total - CNT_W'(1));
    assign w_emit  = w_xfer && ((r_lane == LAST_LANE) || w_last);
    assign w_elem  = relu_clamp(r_relu, din[WI-1]) ? '0 : din;

    ofm_lane_packer #(
        .WI     (WI),
        .PACK   (PACK),
        .LANE_W (LANE_W)
    ) u_packer (
        .clk    (clk),
        .rstn   (rstn),
        .i_clr  (w_start),
        .i_wr   (w_xfer),
        .i_emit (w_emit),
        .i_lane (r_lane),
        .i_data (w_elem),
        .o_data (bram_data),
        .o_we   (bram_we)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_base     <= '0;
            r_word_idx <= '0;
            r_addr     <= '0;
            r_relu     <= 1'b0;
            r_total    <= '0;
            r_elem_cnt <= '0;
            r_lane     <= '0;
            r_din_rdy  <= 1'b0;
            r_done     <= 1'b0;
            r_idle     <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (ap_start) begin
                        r_base     <= base_addr;
                        r_relu     <= relu_en;
                        r_total    <= w_total;
                        r_elem_cnt <= '0;
                        r_lane     <= '0;
                        r_word_idx <= '0;
                        r_err      <= 1'b0;
                        r_idle     <= 1'b0;
                        if (w_total == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state   <= ST_RUN;
                            r_din_rdy <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (w_xfer) begin
                        r_elem_cnt <= r_elem_cnt + CNT_W'(1);
                        r_lane     <= (r_lane == LAST_LANE) ? '0 : r_lane + LANE_W'(1);
                        if (w_emit) begin
                            r_addr     <= r_base + r_word_idx;
                            r_word_idx <= r_word_idx + BRAM_ADDRESS_WIDTH'(1);
                        end
                        // Ready drops together with the final write being presented.
                        if (w_last) begin
                            r_state   <= ST_DONE;
                            r_din_rdy <= 1'b0;
                        end
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_idle  <= 1'b1;
                    r_state <= ST_IDLE;
                    if (din_vld) begin
                        r_err <= 1'b1;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_din_rdy <= 1'b0;
                    r_idle    <= 1'b1;
                end
            endcase
        end
    end

    assign din_rdy      = r_din_rdy;
    assign bram_addr    = r_addr;
    assign ap_done      = r_done;
    assign ap_idle      = r_idle;
    assign err_overflow = r_err;

endmodule

// File: doc/ofm_pack_writer.md
Name: ofm_pack_writer

Overview:
- Collects the serial conv-kernel output stream (one WI-bit element per valid beat) and packs PACK = BRAM_DATA_WIDTH/WI elements per BRAM word.
- Writes each word to the output-feature BRAM at a programmable base address, with per-lane write strobes.
- Over its predecessor it adds: generic pack factor, ofm height separate from width, base address, optional ReLU, ready/valid input, flush of a final partial word, and a sticky overflow error.
- Sits between the conv kernel output and the OFM BRAM port; started and completed with the ap_start/ap_done protocol.

Parameters:
- WI, 8, element width in bits (signed).
- BRAM_DATA_WIDTH, 32, BRAM word width; must be an integer multiple of WI, PACK = BRAM_DATA_WIDTH/WI >= 1.
- BRAM_ADDRESS_WIDTH, 14, BRAM word-address width.
- DIM_W, 9, width of the ofm_w, ofm_h and out_ch config inputs.
- CNT_W, 24, element counter width; must hold ofm_w*ofm_h*out_ch.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- ap_start  in  1  start request, sampled in IDLE only.
- base_addr  in  BRAM_ADDRESS_WIDTH  first word address, latched at start.
- ofm_w  in  DIM_W  ofm width, latched at start.
- ofm_h  in  DIM_W  ofm height, latched at start.
- out_ch  in  DIM_W  output channels, latched at start.
- relu_en  in  1  clamp negative elements to 0, latched at start.
- din  in  WI  conv output element.
- din_vld  in  1  din valid.
- din_rdy  out  1  block accepts din; a beat transfers when din_vld && din_rdy.
- bram_addr  out  BRAM_ADDRESS_WIDTH  write word address.
- bram_data  out  BRAM_DATA_WIDTH  packed write data; lane i = bits [i*WI +: WI].
- bram_we  out  PACK  per-lane write strobe.
- ap_done  out  1  one-cycle completion pulse.
- ap_idle  out  1  high in IDLE.
- err_overflow  out  1  sticky protocol error.

Behaviour:
- Reset: state IDLE. All outputs 0 except ap_idle = 1. Internal counters and pack register cleared. Reset mid-operation abandons the job; no further writes.
- States are IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - ap_idle = 1, din_rdy = 0.
  - On ap_start: latch config, total = ofm_w*ofm_h*out_ch computed at CNT_W bits, clear elem_cnt, lane and word_idx; clear err_overflow.
  - If total == 0, go to DONE. Otherwise go to RUN.
- RUN:
  - din_rdy = 1.
  - On each transfer: v = (relu_en && din[WI-1]) ? 0 : din. Store v in pack lane `lane`, set strobe bit `lane`, then advance lane (wraps at PACK) and elem_cnt.
  - A word is emitted when lane == PACK-1 or elem_cnt == total-1. It appears in the cycle after the accepting edge:
    - bram_we = accumulated strobes;
    - bram_data = pack register with unfilled lanes 0;
    - bram_addr = (base_addr + word_idx) mod 2^BRAM_ADDRESS_WIDTH.
  - After emitting, the pack register and strobes clear and word_idx increments.
  - bram_we is 0 in every cycle with no emitted word. No write is issued for gaps in din_vld.
  - The final beat (elem_cnt == total-1) moves the state to DONE; din_rdy drops in the same cycle the final write is presented.
  - ap_start is ignored while in RUN.
- DONE:
  - Lasts one cycle; ap_done is registered to pulse in the cycle after the final bram write (or two cycles after ap_start when total == 0). Then return to IDLE.
  - din_vld high while in DONE (stream longer than total) sets err_overflow. err_overflow stays high until the next accepted ap_start or reset.
- Latency: element accepted at edge k is written at the cycle after edge k (single-cycle pipeline). Throughput is 1 element/clock.
- PACK == 1: every beat produces a full write.

Decomposition:
- Shared package ofm_pkg: state encoding (IDLE/RUN/DONE), PACK derivation function, and the relu/saturation helper reused by future requantise blocks.
- One natural sub-module, ofm_lane_packer: lane register, strobe accumulation, and clear-on-emit. The FSM, counters and address generation stay in the top.

Test Plan:
- Basic pack: WI=8, PACK=4, 2x2x2, base 0x010, din 0x01..0x08 back-to-back -> write addr 0x010 data 0x04030201 we 1111, then addr 0x011 data 0x08070605 we 1111; ap_done pulses one cycle after the second write; exactly 2 writes.
- Partial flush: 3x3x1, din 1..9 -> addr 0/1 full words, addr 2 data 0x00000009 we 0001; ap_done follows.
- ReLU: relu_en=1, 1x1x4, din 0x80,0x7F,0xFF,0x05 -> data 0x05007F00 we 1111. With relu_en=0 -> 0x05FF7F80.
- Bubbles: same as the basic-pack case, with din_vld toggling every other cycle -> identical writes; bram_we never high on gap cycles; 8 transfers total.
- Zero/wrap: out_ch=0 -> no writes, ap_done two cycles after start. base_addr=0x3FFF, 1x1x8 -> writes at 0x3FFF then 0x0000.
- Reset and error: rstn low after 5 beats -> all outputs 0, ap_idle=1; a new job writes from base_addr again. Extra din_vld during DONE -> err_overflow=1, held until the next ap_start.
